// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: 8259-style priority resolver owning the ISR, INTA handshake and OCW2 EOI/rotation.
module pic_priority_resolver #(
  parameter int NUM_IR = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IR-1:0] IRR,
  input  logic              aeoi,
  input  logic              inta,
  input  logic              eoi_strobe,
  input  logic [2:0]        eoi_cmd,
  input  logic [2:0]        eoi_level,
  output logic              INT,
  output logic [NUM_IR-1:0] ISR,
  output logic              resetIRRbit,
  output logic [NUM_IR-1:0] irr_clear,
  output logic              vector_valid,
  output logic [2:0]        vector_level,
  output logic              spurious
);
  typedef enum logic {IDLE, ACK2} state_t;
  state_t state, state_n;
  logic [2:0] lowest_prio, lp_n, ack_level;
  logic rotate_aeoi, rot_n, ack_spur, first, second, eoi_ns, eoi_sp, int_n;
  logic [3:0] isr_hi, req_hi;
  logic [NUM_IR-1:0] qual, set_mask, aeoi_clr, eoi_clr, isr_n;
  // rank 0 is the highest priority, i.e. the level just after lowest_prio
  function automatic logic [2:0] rank(input logic [2:0] l, input logic [2:0] lp);
    return l - lp - 3'd1;
  endfunction
  // {found, level} of the highest-priority set bit; scanning lowest priority first so the best match lands last
  function automatic logic [3:0] highest(input logic [NUM_IR-1:0] v, input logic [2:0] lp);
    logic [3:0] r;
    logic [2:0] l;
    r = '0;
    for (int k = 8; k >= 1; k--) begin
      l = lp + 3'(k);
      if (v[l]) r = {1'b1, l};
    end
    return r;
  endfunction
  always_comb begin
    isr_hi = highest(ISR, lowest_prio);
    qual = '0;
    for (int n = 0; n < NUM_IR; n++)
      qual[n] = IRR[n] && (!isr_hi[3] || rank(3'(n), lowest_prio) < rank(isr_hi[2:0], lowest_prio));
    req_hi = highest(qual, lowest_prio);
    first = inta && state == IDLE;
    second = inta && state == ACK2;
    state_n = first ? ACK2 : second ? IDLE : state;
    set_mask = (first && req_hi[3]) ? NUM_IR'(1) << req_hi[2:0] : '0;
    aeoi_clr = (second && aeoi && !ack_spur) ? NUM_IR'(1) << ack_level : '0;
    eoi_ns = eoi_strobe && eoi_cmd[0] && !eoi_cmd[1];
    eoi_sp = eoi_strobe && eoi_cmd[0] && eoi_cmd[1];
    eoi_clr = eoi_sp ? NUM_IR'(1) << eoi_level : (eoi_ns && isr_hi[3]) ? NUM_IR'(1) << isr_hi[2:0] : '0;
    isr_n = (ISR & ~(eoi_clr | aeoi_clr)) | set_mask;
    lp_n = (eoi_strobe && eoi_cmd[2:1] == 2'b11) ? eoi_level :
           (eoi_ns && eoi_cmd[2] && isr_hi[3]) ? isr_hi[2:0] :
           (second && aeoi && !ack_spur && rotate_aeoi) ? ack_level : lowest_prio;
    rot_n = (eoi_strobe && eoi_cmd == 3'b100) ? 1'b1 : (eoi_strobe && eoi_cmd == 3'b000) ? 1'b0 : rotate_aeoi;
    int_n = state_n == IDLE && |qual;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      INT <= 1'b0;
      ISR <= '0;
      resetIRRbit <= 1'b0;
      irr_clear <= '0;
      vector_valid <= 1'b0;
      vector_level <= 3'd0;
      spurious <= 1'b0;
      lowest_prio <= 3'd7;
      rotate_aeoi <= 1'b0;
      ack_level <= 3'd0;
      ack_spur <= 1'b0;
    end else begin
      state <= state_n;
      INT <= int_n;
      ISR <= isr_n;
      resetIRRbit <= first && req_hi[3];
      irr_clear <= set_mask;
      vector_valid <= second;
      vector_level <= second ? ack_level : 3'd0;
      spurious <= second && ack_spur;
      lowest_prio <= lp_n;
      rotate_aeoi <= rot_n;
      ack_level <= first ? (req_hi[3] ? req_hi[2:0] : 3'd7) : ack_level;
      ack_spur <= first ? !req_hi[3] : ack_spur;
    end
  end
endmodule

// File: tb/tb_pic_priority_resolver.sv
// tb_pic_priority_resolver: cycle-by-cycle vector table with a scoreboard for acknowledge vectors.
module tb_pic_priority_resolver;
  logic clk, reset, aeoi, inta, eoi_strobe;
  logic [7:0] IRR;
  logic [2:0] eoi_cmd, eoi_level;
  logic INT, resetIRRbit, vector_valid, spurious;
  logic [7:0] ISR, irr_clear;
  logic [2:0] vector_level;
  int tests = 0, fails = 0;
  logic [3:0] sb[$];

  typedef struct {
    logic rst; logic [7:0] irr; logic ae, ia, es; logic [2:0] cmd, lvl;
    logic vv; logic [2:0] vl; logic vs;
    logic xint; logic [7:0] xisr; logic xrst; logic [7:0] xclr;
  } vec_t;
  vec_t vecs[$];

  pic_priority_resolver #(.NUM_IR(8)) dut (
    .clk(clk), .reset(reset), .IRR(IRR), .aeoi(aeoi), .inta(inta),
    .eoi_strobe(eoi_strobe), .eoi_cmd(eoi_cmd), .eoi_level(eoi_level),
    .INT(INT), .ISR(ISR), .resetIRRbit(resetIRRbit), .irr_clear(irr_clear),
    .vector_valid(vector_valid), .vector_level(vector_level), .spurious(spurious)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic vec_t v(logic rst, logic [7:0] irr, logic ae, logic ia, logic es, logic [2:0] cmd, logic [2:0] lvl,
                             logic vv, logic [2:0] vl, logic vs, logic xint, logic [7:0] xisr, logic xrst, logic [7:0] xclr);
    vec_t r;
    r.rst = rst; r.irr = irr; r.ae = ae; r.ia = ia; r.es = es; r.cmd = cmd; r.lvl = lvl;
    r.vv = vv; r.vl = vl; r.vs = vs; r.xint = xint; r.xisr = xisr; r.xrst = xrst; r.xclr = xclr;
    return r;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(vec_t t, string nm);
    @(negedge clk);
    reset = t.rst; IRR = t.irr; aeoi = t.ae; inta = t.ia;
    eoi_strobe = t.es; eoi_cmd = t.cmd; eoi_level = t.lvl;
    if (t.vv) sb.push_back({t.vs, t.vl});
    @(posedge clk);
    #1;
    chk({nm, " INT"}, {7'd0, INT}, {7'd0, t.xint});
    chk({nm, " ISR"}, ISR, t.xisr);
    chk({nm, " resetIRRbit"}, {7'd0, resetIRRbit}, {7'd0, t.xrst});
    chk({nm, " irr_clear"}, irr_clear, t.xclr);
    chk({nm, " vector_valid"}, {7'd0, vector_valid}, {7'd0, t.vv});
  endtask

  always @(posedge clk) begin
    #2;
    if (vector_valid) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL vector_unexpected: got level %0d spur %0b expected none", vector_level, spurious);
      end else begin
        logic [3:0] e;
        e = sb.pop_front();
        chk("vector_level", {5'd0, vector_level}, {5'd0, e[2:0]});
        chk("spurious", {7'd0, spurious}, {7'd0, e[3]});
      end
    end
  end

  initial begin
    reset = 1; IRR = 0; aeoi = 0; inta = 0; eoi_strobe = 0; eoi_cmd = 0; eoi_level = 0;
    //            rst irr    ae ia es cmd  lvl  vv vl spur   INT ISR    rst clr
    // IR2 and IR5 pending: IR2 wins, IR5 then blocked by in-service IR2
    vecs.push_back(v(1, 8'h00, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 8'h24, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 8'h24, 0, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 8'h04, 1, 8'h04));
    vecs.push_back(v(0, 8'h20, 0, 1, 0, 3'd0, 3'd0, 1, 3'd2, 0, 0, 8'h04, 0, 8'h00));
    vecs.push_back(v(0, 8'h20, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 8'h04, 0, 8'h00));
    vecs.push_back(v(0, 8'h20, 0, 0, 1, 3'd1, 3'd0, 0, 3'd0, 0, 0, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 8'h20, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 8'h00, 0, 8'h00));
    // IR5 in service, IR0 nests above it
    vecs.push_back(v(0, 8'h20, 0, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 8'h20, 1, 8'h20));
    vecs.push_back(v(0, 8'h00, 0, 1, 0, 3'd0, 3'd0, 1, 3'd5, 0, 0, 8'h20, 0, 8'h00));
    vecs.push_back(v(0, 8'h01, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 8'h20, 0, 8'h00));
    vecs.push_back(v(0, 8'h01, 0, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 8'h21, 1, 8'h01));
    vecs.push_back(v(0, 8'h00, 0, 1, 0, 3'd0, 3'd0, 1, 3'd0, 0, 0, 8'h21, 0, 8'h00));
    vecs.push_back(v(0, 8'h00, 0, 0, 1, 3'd1, 3'd0, 0, 3'd0, 0, 0, 8'h20, 0, 8'h00));
    vecs.push_back(v(0, 8'h00, 0, 0, 1, 3'd1, 3'd0, 0, 3'd0, 0, 0, 8'h00, 0, 8'h00));
    // AEOI with rotation: IR3 acked then IR4 outranks IR3
    vecs.push_back(v(0, 8'h08, 1, 0, 1, 3'd4, 3'd0, 0, 3'd0, 0, 1, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 8'h08, 1, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 8'h08, 1, 8'h08));
    vecs.push_back(v(0, 8'h00, 1, 1, 0, 3'd0, 3'd0, 1, 3'd3, 0, 0, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 8'h18, 1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 8'h18, 1, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 8'h10, 1, 8'h10));
    vecs.push_back(v(0, 8'h08, 1, 1, 0, 3'd0, 3'd0, 1, 3'd4, 0, 0, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 8'h08, 0, 0, 1, 3'd0, 3'd0, 0, 3'd0, 0, 1, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 8'h00, 0, 0, 1, 3'd6, 3'd7, 0, 3'd0, 0, 0, 8'h00, 0, 8'h00));
    // spurious acknowledge
    vecs.push_back(v(0, 8'h00, 0, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 8'h00, 0, 1, 0, 3'd0, 3'd0, 1, 3'd7, 1, 0, 8'h00, 0, 8'h00));
    // set priority to 4, rotate on specific EOI 5, then IR6 beats IR0
    vecs.push_back(v(0, 8'h21, 0, 0, 1, 3'd6, 3'd4, 0, 3'd0, 0, 1, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 8'h21, 0, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 8'h20, 1, 8'h20));
    vecs.push_back(v(0, 8'h01, 0, 1, 0, 3'd0, 3'd0, 1, 3'd5, 0, 0, 8'h20, 0, 8'h00));
    vecs.push_back(v(0, 8'h01, 0, 0, 1, 3'd7, 3'd5, 0, 3'd0, 0, 0, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 8'h41, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 8'h41, 0, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 8'h40, 1, 8'h40));
    vecs.push_back(v(0, 8'h01, 0, 1, 0, 3'd0, 3'd0, 1, 3'd6, 0, 0, 8'h40, 0, 8'h00));
    vecs.push_back(v(0, 8'h00, 0, 0, 1, 3'd1, 3'd0, 0, 3'd0, 0, 0, 8'h00, 0, 8'h00));
    // reset inside ACK2, next inta is a first pulse
    vecs.push_back(v(0, 8'h02, 0, 0, 1, 3'd6, 3'd7, 0, 3'd0, 0, 1, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 8'h02, 0, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 8'h02, 1, 8'h02));
    vecs.push_back(v(1, 8'h02, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 8'h02, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 8'h00, 0, 8'h00));
    vecs.push_back(v(0, 8'h02, 0, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 8'h02, 1, 8'h02));
    vecs.push_back(v(0, 8'h00, 0, 1, 0, 3'd0, 3'd0, 1, 3'd1, 0, 0, 8'h02, 0, 8'h00));
    for (int i = 0; i < vecs.size(); i++) run(vecs[i], $sformatf("row%0d", i));
    // same-cycle set vs specific EOI on IR0: set wins
    run(v(0, 8'h01, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 1, 8'h02, 0, 8'h00), "nest_int");
    run(v(0, 8'h01, 0, 1, 1, 3'd3, 3'd0, 0, 3'd0, 0, 0, 8'h03, 1, 8'h01), "set_wins");
    // AEOI clear of IR0 plus specific EOI of IR1: both clear
    run(v(0, 8'h00, 1, 1, 1, 3'd3, 3'd1, 1, 3'd0, 0, 0, 8'h00, 0, 8'h00), "or_clears");
    // rotating AEOI on IR4 collides with set-priority 2: command wins
    run(v(0, 8'h00, 0, 0, 1, 3'd4, 3'd0, 0, 3'd0, 0, 0, 8'h00, 0, 8'h00), "rot_on");
    run(v(0, 8'h10, 0, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 8'h10, 1, 8'h10), "ack4");
    run(v(0, 8'h00, 1, 1, 1, 3'd6, 3'd2, 1, 3'd4, 0, 0, 8'h00, 0, 8'h00), "lp_conflict");
    // rotate non-specific EOI with empty ISR must not rotate
    run(v(0, 8'h09, 0, 0, 1, 3'd5, 3'd0, 0, 3'd0, 0, 1, 8'h00, 0, 8'h00), "ns_noop");
    run(v(0, 8'h09, 0, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 8'h08, 1, 8'h08), "lp2_ack3");
    run(v(0, 8'h01, 0, 1, 0, 3'd0, 3'd0, 1, 3'd3, 0, 0, 8'h08, 0, 8'h00), "lp2_vec");
    run(v(0, 8'h00, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 8'h08, 0, 8'h00), "idle");
    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
